mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM stage load/store unit plus MEM/WB pipeline register.
- Accepts a valid EX/MEM bundle and runs the data-RAM access with a req/ack handshake.
- Stalls the pipeline while the RAM is busy, and detects misaligned accesses and RAM timeouts.
- Presents a registered bundle to WB (loaded word, mem flags, reg/HILO write info). WB performs byte/half extraction.

Parameters:
- ACK_TIMEOUT, 16, number of cycles spent in WAIT without ram_ack before the access aborts with bus_err.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  cancel the current MEM instruction and any in-flight access.
- in_valid  in  1  EX/MEM bundle valid.
- mem_read_flag_in  in  1  load.
- mem_write_flag_in  in  1  store.
- mem_sign_flag_in  in  1  signed load.
- mem_sel_in  in  4  0001 byte, 0011 half, 1111 word.
- mem_write_data_in  in  32  store data, right-aligned.
- result_in  in  32  ALU result / effective address.
- reg_write_en_in  in  1  register write enable.
- reg_write_addr_in  in  5  register write address.
- current_pc_addr_in  in  32  PC of the instruction.
- hi_write_data_in  in  32  HI write data.
- lo_write_data_in  in  32  LO write data.
- hilo_write_en_in  in  1  HILO write enable.
- ram_req  out  1  access request; held until ack.
- ram_addr  out  32  word-aligned address, {result[31:2],2'b00}.
- ram_write_en  out  4  byte-lane strobes; 0000 for a read.
- ram_write_data  out  32  lane-replicated store data.
- ram_ack  in  1  access complete; read data valid this cycle.
- ram_read_data  in  32  read data.
- stall_req  out  1  hold IF/ID/EX.
- adel  out  1  misaligned-load pulse, 1 cycle.
- ades  out  1  misaligned-store pulse, 1 cycle.
- bus_err  out  1  timeout pulse, 1 cycle.
- Registered to WB (same names with _out suffix): mem_read_flag, mem_write_flag, mem_sign_flag, mem_sel, result, reg_write_en, reg_write_addr, current_pc_addr, hi_write_data, lo_write_data, hilo_write_en, and wb_ram_read_data (32 bits).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all outputs 0, counter 0.
- FSM states: IDLE, WAIT.
- Misalignment:
  - half access with result[0]=1 is misaligned;
  - word access with result[1:0]≠0 is misaligned;
  - misaligned load → adel, misaligned store → ades;
  - no ram_req is issued; the WB bundle is a bubble (all enables 0) next edge.
- IDLE, valid aligned load/store, no flush:
  - ram_req, ram_addr, ram_write_en and ram_write_data are driven combinationally this cycle;
  - stall_req=1 combinationally;
  - the bundle is captured into holding regs; next state WAIT.
- Store strobes:
  - byte: 0001<<result[1:0];
  - half: 0011<<result[1:0];
  - word: 1111.
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- WAIT:
  - ram_req and the other RAM outputs are held stable from the holding regs;
  - stall_req=1; the counter increments each cycle;
  - the WB bundle is a bubble.
- ram_ack sampled high in WAIT:
  - wb_ram_read_data ← ram_read_data;
  - the held bundle goes to WB on that edge;
  - next state IDLE; stall_req drops in the next cycle.
- Minimum memory-op latency is 2 cycles with ack on the first WAIT cycle. The pipeline stalls for (wait cycles + 1).
- Timeout: counter reaches ACK_TIMEOUT without ack → bus_err pulse, WB bubble, IDLE. A late ack arriving in IDLE is ignored.
- Non-memory valid instruction in IDLE: the bundle passes to WB on the next edge, 1-cycle latency; stall_req=0.
- in_valid=0: WB bubble.
- flush:
  - has priority over everything;
  - the next edge forces IDLE and a WB bubble and clears the counter;
  - ram_req drops combinationally in the flush cycle;
  - an ack in the same cycle as flush is discarded.
- Store results to WB: reg_write_en_out=0 unless the instruction itself writes a register (as given by the input).

Decomposition:
- Shared package/header (bus.v):
  - DATA_BUS, ADDR_BUS, REG_ADDR_BUS, MEM_SEL_BUS widths;
  - MEM_SEL_BYTE/HALF/WORD constants;
  - LSU state encoding.
- One natural sub-module, lsu_store_align: a combinational block producing strobes and lane-replicated data from mem_sel, address[1:0] and write data.

Test Plan:
- Word load (lw), addr 0x100, ack on the 2nd WAIT cycle with data 0xDEADBEEF → ram_addr=0x100, ram_write_en=0000, stall_req high 3 cycles, then WB gets wb_ram_read_data=0xDEADBEEF, mem_sel_out=1111.
- Byte store (sb), addr 0x103, data 0x000000AB, immediate ack → ram_write_en=1000, ram_write_data=0xABABABAB, ram_addr=0x100.
- Half load (lh) at addr 0x101 → adel=1 for 1 cycle, ram_req never high, reg_write_en_out=0.
- Load with ram_ack never asserted, ACK_TIMEOUT=16 → stall_req high 17 cycles, bus_err pulse, WB bubble, next instruction proceeds.
- flush in the 2nd WAIT cycle with ack in the same cycle → no WB write, state IDLE, ram_req low.
- rst_n low mid-WAIT → all outputs 0 immediately; after release, a non-memory add passes to WB in 1 cycle.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared widths, access-size encodings, LSU state encoding and the WB bundle type
// for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

    localparam int DATA_BUS     = 32;
    localparam int ADDR_BUS     = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int MEM_SEL_BUS  = 4;

    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_t;

    typedef struct packed {
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_sign;
        logic [MEM_SEL_BUS-1:0]  mem_sel;
        logic [DATA_BUS-1:0]     result;
        logic                    reg_write_en;
        logic [REG_ADDR_BUS-1:0] reg_write_addr;
        logic [ADDR_BUS-1:0]     pc;
        logic [DATA_BUS-1:0]     hi;
        logic [DATA_BUS-1:0]     lo;
        logic                    hilo_write_en;
    } wb_bundle_t;

    // Half accesses need an even address, word accesses a multiple of four.
    function automatic logic misaligned(input logic [MEM_SEL_BUS-1:0] sel,
                                        input logic [1:0] addr_lo);
        case (sel)
            MEM_SEL_HALF: return addr_lo[0];
            MEM_SEL_WORD: return addr_lo != 2'b00;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-RAM request/acknowledge bus between the LSU (master) and the RAM (slave).
interface mem_stage_lsu_if;
    import mem_stage_lsu_pkg::*;

    logic                   ram_req;
    logic [ADDR_BUS-1:0]    ram_addr;
    logic [MEM_SEL_BUS-1:0] ram_write_en;
    logic [DATA_BUS-1:0]    ram_write_data;
    logic                   ram_ack;
    logic [DATA_BUS-1:0]    ram_read_data;

    modport master (
        output ram_req, ram_addr, ram_write_en, ram_write_data,
        input  ram_ack, ram_read_data
    );

    modport slave (
        input  ram_req, ram_addr, ram_write_en, ram_write_data,
        output ram_ack, ram_read_data
    );

endinterface

// File: rtl/lsu_store_align.sv
// Byte-lane strobes and lane-replicated store data; all zero for non-store accesses.
module lsu_store_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [MEM_SEL_BUS-1:0] mem_sel,
    input  logic [1:0]             addr_lo,
    input  logic [DATA_BUS-1:0]    write_data,
    input  logic                   store,
    output logic [MEM_SEL_BUS-1:0] strobe,
    output logic [DATA_BUS-1:0]    lane_data
);

    always_comb begin
        strobe    = '0;
        lane_data = '0;
        if (store) begin
            case (mem_sel)
                MEM_SEL_BYTE: begin
                    strobe    = 4'b0001 << addr_lo;
                    lane_data = {4{write_data[7:0]}};
                end
                MEM_SEL_HALF: begin
                    strobe    = 4'b0011 << addr_lo;
                    lane_data = {2{write_data[15:0]}};
                end
                MEM_SEL_WORD: begin
                    strobe    = 4'b1111;
                    lane_data = write_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs the data-RAM handshake, stalls upstream while
// waiting, flags misalignment/timeouts, and registers the bundle handed to WB.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic                    mem_read_flag_in,
    input  logic                    mem_write_flag_in,
    input  logic                    mem_sign_flag_in,
    input  logic [MEM_SEL_BUS-1:0]  mem_sel_in,
    input  logic [DATA_BUS-1:0]     mem_write_data_in,
    input  logic [DATA_BUS-1:0]     result_in,
    input  logic                    reg_write_en_in,
    input  logic [REG_ADDR_BUS-1:0] reg_write_addr_in,
    input  logic [ADDR_BUS-1:0]     current_pc_addr_in,
    input  logic [DATA_BUS-1:0]     hi_write_data_in,
    input  logic [DATA_BUS-1:0]     lo_write_data_in,
    input  logic                    hilo_write_en_in,
    mem_stage_lsu_if.master         ram,
    output logic                    stall_req,
    output logic                    adel,
    output logic                    ades,
    output logic                    bus_err,
    output logic                    mem_read_flag_out,
    output logic                    mem_write_flag_out,
    output logic                    mem_sign_flag_out,
    output logic [MEM_SEL_BUS-1:0]  mem_sel_out,
    output logic [DATA_BUS-1:0]     result_out,
    output logic                    reg_write_en_out,
    output logic [REG_ADDR_BUS-1:0] reg_write_addr_out,
    output logic [ADDR_BUS-1:0]     current_pc_addr_out,
    output logic [DATA_BUS-1:0]     hi_write_data_out,
    output logic [DATA_BUS-1:0]     lo_write_data_out,
    output logic                    hilo_write_en_out,
    output logic [DATA_BUS-1:0]     wb_ram_read_data
);

    lsu_state_t             state, state_next;
    logic [CNT_W-1:0]       cnt;
    wb_bundle_t             in_bundle, hold_p1, wb_p2;
    logic [DATA_BUS-1:0]    hold_wdata_p1;
    logic [DATA_BUS-1:0]    rdata_p2;
    logic                   is_mem, mis, start, timeout, waiting, req;
    logic [MEM_SEL_BUS-1:0] strobe;
    logic [DATA_BUS-1:0]    lane_data;
    logic [DATA_BUS-1:0]    addr_src;

    assign in_bundle = '{
        mem_read:       mem_read_flag_in,
        mem_write:      mem_write_flag_in,
        mem_sign:       mem_sign_flag_in,
        mem_sel:        mem_sel_in,
        result:         result_in,
        reg_write_en:   reg_write_en_in,
        reg_write_addr: reg_write_addr_in,
        pc:             current_pc_addr_in,
        hi:             hi_write_data_in,
        lo:             lo_write_data_in,
        hilo_write_en:  hilo_write_en_in
    };

    assign is_mem  = mem_read_flag_in | mem_write_flag_in;
    assign mis     = misaligned(mem_sel_in, result_in[1:0]);
    assign start   = rst_n && !flush && (state == LSU_IDLE) && in_valid && is_mem && !mis;
    assign timeout = (cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign waiting = (state == LSU_WAIT);

    // While waiting, the RAM side is driven from the captured copy so upstream may change.
    assign addr_src = waiting ? hold_p1.result : result_in;

    lsu_store_align u_store_align (
        .mem_sel    (waiting ? hold_p1.mem_sel   : mem_sel_in),
        .addr_lo    (addr_src[1:0]),
        .write_data (waiting ? hold_wdata_p1     : mem_write_data_in),
        .store      (waiting ? hold_p1.mem_write : mem_write_flag_in),
        .strobe     (strobe),
        .lane_data  (lane_data)
    );

    assign ram.ram_req        = req;
    assign ram.ram_addr       = req ? {addr_src[31:2], 2'b00} : '0;
    assign ram.ram_write_en   = req ? strobe : '0;
    assign ram.ram_write_data = req ? lane_data : '0;

    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall_req  = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (start) begin
                    state_next = LSU_WAIT;
                    req        = 1'b1;
                    stall_req  = 1'b1;
                end
            end
            LSU_WAIT: begin
                req       = 1'b1;
                stall_req = 1'b1;
                if (ram.ram_ack || timeout) state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
        endcase
        if (flush) begin
            state_next = LSU_IDLE;
            req        = 1'b0;
            stall_req  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (waiting && state_next == LSU_WAIT) ? cnt + 1'b1 : '0;
        end
    end

    // p1: bundle captured when an access is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_p1       <= '0;
            hold_wdata_p1 <= '0;
        end else if (start) begin
            hold_p1       <= in_bundle;
            hold_wdata_p1 <= mem_write_data_in;
        end
    end

    // p2: MEM/WB register; anything not explicitly delivered is a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_p2    <= '0;
            rdata_p2 <= '0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            wb_p2    <= '0;
            rdata_p2 <= '0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            bus_err  <= 1'b0;
            if (!flush) begin
                if (state == LSU_IDLE) begin
                    if (in_valid && !is_mem) begin
                        wb_p2 <= in_bundle;
                    end else if (in_valid && mis) begin
                        adel <= mem_read_flag_in;
                        ades <= mem_write_flag_in & ~mem_read_flag_in;
                    end
                end else if (ram.ram_ack) begin
                    wb_p2    <= hold_p1;
                    rdata_p2 <= ram.ram_read_data;
                end else if (timeout) begin
                    bus_err <= 1'b1;
                end
            end
        end
    end

    assign mem_read_flag_out   = wb_p2.mem_read;
    assign mem_write_flag_out  = wb_p2.mem_write;
    assign mem_sign_flag_out   = wb_p2.mem_sign;
    assign mem_sel_out         = wb_p2.mem_sel;
    assign result_out          = wb_p2.result;
    assign reg_write_en_out    = wb_p2.reg_write_en;
    assign reg_write_addr_out  = wb_p2.reg_write_addr;
    assign current_pc_addr_out = wb_p2.pc;
    assign hi_write_data_out   = wb_p2.hi;
    assign lo_write_data_out   = wb_p2.lo;
    assign hilo_write_en_out   = wb_p2.hilo_write_en;
    assign wb_ram_read_data    = rdata_p2;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: WB bundles are checked against a scoreboard
// queue filled as instructions are issued; RAM-side behaviour is checked inline.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid, mem_read_flag_in, mem_write_flag_in, mem_sign_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_write_data_in, result_in, current_pc_addr_in;
    logic [31:0] hi_write_data_in, lo_write_data_in;
    logic        reg_write_en_in, hilo_write_en_in;
    logic [4:0]  reg_write_addr_in;

    logic        stall_req, adel, ades, bus_err;
    logic        mem_read_flag_out, mem_write_flag_out, mem_sign_flag_out;
    logic [3:0]  mem_sel_out;
    logic [31:0] result_out, current_pc_addr_out, hi_write_data_out, lo_write_data_out;
    logic        reg_write_en_out, hilo_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic [31:0] wb_ram_read_data;

    int tests = 0;
    int fails = 0;
    int n;
    logic [173:0] exp_q[$];

    mem_stage_lsu_if bus();

    mem_stage_lsu #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .in_valid            (in_valid),
        .mem_read_flag_in    (mem_read_flag_in),
        .mem_write_flag_in   (mem_write_flag_in),
        .mem_sign_flag_in    (mem_sign_flag_in),
        .mem_sel_in          (mem_sel_in),
        .mem_write_data_in   (mem_write_data_in),
        .result_in           (result_in),
        .reg_write_en_in     (reg_write_en_in),
        .reg_write_addr_in   (reg_write_addr_in),
        .current_pc_addr_in  (current_pc_addr_in),
        .hi_write_data_in    (hi_write_data_in),
        .lo_write_data_in    (lo_write_data_in),
        .hilo_write_en_in    (hilo_write_en_in),
        .ram                 (bus),
        .stall_req           (stall_req),
        .adel                (adel),
        .ades                (ades),
        .bus_err             (bus_err),
        .mem_read_flag_out   (mem_read_flag_out),
        .mem_write_flag_out  (mem_write_flag_out),
        .mem_sign_flag_out   (mem_sign_flag_out),
        .mem_sel_out         (mem_sel_out),
        .result_out          (result_out),
        .reg_write_en_out    (reg_write_en_out),
        .reg_write_addr_out  (reg_write_addr_out),
        .current_pc_addr_out (current_pc_addr_out),
        .hi_write_data_out   (hi_write_data_out),
        .lo_write_data_out   (lo_write_data_out),
        .hilo_write_en_out   (hilo_write_en_out),
        .wb_ram_read_data    (wb_ram_read_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        in_valid = 0; mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_flag_in = 0;
        mem_sel_in = 0; mem_write_data_in = 0; result_in = 0; reg_write_en_in = 0;
        reg_write_addr_in = 0; current_pc_addr_in = 0; hi_write_data_in = 0;
        lo_write_data_in = 0; hilo_write_en_in = 0;
    endtask

    task automatic set_instr(input logic rd, input logic wr, input logic sg,
                             input logic [3:0] sel, input logic [31:0] wdata,
                             input logic [31:0] res, input logic rwe, input logic [4:0] rwa,
                             input logic [31:0] pc, input logic [31:0] hi,
                             input logic [31:0] lo, input logic hwe);
        in_valid = 1; mem_read_flag_in = rd; mem_write_flag_in = wr; mem_sign_flag_in = sg;
        mem_sel_in = sel; mem_write_data_in = wdata; result_in = res; reg_write_en_in = rwe;
        reg_write_addr_in = rwa; current_pc_addr_in = pc; hi_write_data_in = hi;
        lo_write_data_in = lo; hilo_write_en_in = hwe;
    endtask

    // Expected WB view of the instruction currently on the inputs.
    function automatic logic [173:0] exp_now(input logic [31:0] rdata);
        return {mem_read_flag_in, mem_write_flag_in, mem_sign_flag_in, mem_sel_in, result_in,
                reg_write_en_in, reg_write_addr_in, current_pc_addr_in, hi_write_data_in,
                lo_write_data_in, hilo_write_en_in, rdata};
    endfunction

    task automatic monitor();
        logic [173:0] got, exp;
        got = {mem_read_flag_out, mem_write_flag_out, mem_sign_flag_out, mem_sel_out, result_out,
               reg_write_en_out, reg_write_addr_out, current_pc_addr_out, hi_write_data_out,
               lo_write_data_out, hilo_write_en_out, wb_ram_read_data};
        if (mem_read_flag_out || mem_write_flag_out || reg_write_en_out || hilo_write_en_out) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL wb_unexpected observed=%h expected=bubble", got);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                tests++;
                assert (got === exp) else begin
                    fails++;
                    $error("FAIL wb_bundle observed=%h expected=%h", got, exp);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    initial begin
        set_idle();
        bus.ram_ack = 0;
        bus.ram_read_data = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ram_req", bus.ram_req, 0);
        check("rst_stall", stall_req, 0);
        check("rst_wb_rwe", reg_write_en_out, 0);
        check("rst_wb_rdata", wb_ram_read_data, 0);
        rst_n = 1;
        @(negedge clk);

        // Non-memory add: one-cycle pass-through, no stall
        set_instr(0, 0, 0, 4'b0000, 0, 32'h1234, 1, 5'd3, 32'h400, 0, 0, 0);
        exp_q.push_back(exp_now(32'h0));
        #1;
        check("add_stall", stall_req, 0);
        check("add_ram_req", bus.ram_req, 0);
        cyc();
        check("add_wb_rwe", reg_write_en_out, 1);
        check("add_q_empty", exp_q.size(), 0);

        // lw 0x100, ack on the second WAIT cycle
        set_instr(1, 0, 0, MEM_SEL_WORD, 0, 32'h100, 1, 5'd8, 32'h404, 0, 0, 0);
        exp_q.push_back(exp_now(32'hDEADBEEF));
        #1;
        check("lw_ram_req", bus.ram_req, 1);
        check("lw_ram_addr", bus.ram_addr, 32'h100);
        check("lw_ram_we", bus.ram_write_en, 4'b0000);
        n = int'(stall_req);
        cyc();
        set_idle();
        #1;
        check("lw_hold_req", bus.ram_req, 1);
        check("lw_hold_addr", bus.ram_addr, 32'h100);
        check("lw_wait_bubble", reg_write_en_out, 0);
        n += int'(stall_req);
        cyc();
        bus.ram_ack = 1;
        bus.ram_read_data = 32'hDEADBEEF;
        #1;
        n += int'(stall_req);
        cyc();
        bus.ram_ack = 0;
        bus.ram_read_data = 0;
        #1;
        check("lw_stall_drop", stall_req, 0);
        check("lw_stall_cycles", n, 3);
        check("lw_q_empty", exp_q.size(), 0);

        // sb 0x103, immediate ack
        @(negedge clk);
        set_instr(0, 1, 0, MEM_SEL_BYTE, 32'hAB, 32'h103, 0, 5'd0, 32'h408, 0, 0, 0);
        exp_q.push_back(exp_now(32'h0));
        #1;
        check("sb_ram_req", bus.ram_req, 1);
        check("sb_ram_addr", bus.ram_addr, 32'h100);
        check("sb_ram_we", bus.ram_write_en, 4'b1000);
        check("sb_ram_wdata", bus.ram_write_data, 32'hABABABAB);
        cyc();
        set_idle();
        bus.ram_ack = 1;
        #1;
        check("sb_hold_we", bus.ram_write_en, 4'b1000);
        check("sb_hold_wdata", bus.ram_write_data, 32'hABABABAB);
        cyc();
        bus.ram_ack = 0;
        #1;
        check("sb_q_empty", exp_q.size(), 0);

        // sh 0x102, immediate ack
        @(negedge clk);
        set_instr(0, 1, 0, MEM_SEL_HALF, 32'h1234CDEF, 32'h102, 0, 5'd0, 32'h40C, 0, 0, 0);
        exp_q.push_back(exp_now(32'h0));
        #1;
        check("sh_ram_we", bus.ram_write_en, 4'b1100);
        check("sh_ram_wdata", bus.ram_write_data, 32'hCDEFCDEF);
        cyc();
        set_idle();
        bus.ram_ack = 1;
        #1;
        cyc();
        bus.ram_ack = 0;
        #1;
        check("sh_q_empty", exp_q.size(), 0);

        // lh 0x101: misaligned load
        @(negedge clk);
        set_instr(1, 0, 1, MEM_SEL_HALF, 0, 32'h101, 1, 5'd4, 32'h410, 0, 0, 0);
        #1;
        check("lh_mis_ram_req", bus.ram_req, 0);
        check("lh_mis_stall", stall_req, 0);
        cyc();
        set_idle();
        #1;
        check("lh_adel", adel, 1);
        check("lh_ades", ades, 0);
        check("lh_wb_rwe", reg_write_en_out, 0);
        check("lh_ram_req_after", bus.ram_req, 0);
        cyc();
        check("lh_adel_pulse", adel, 0);

        // sw 0x102: misaligned store
        set_instr(0, 1, 0, MEM_SEL_WORD, 32'h11, 32'h102, 0, 5'd0, 32'h414, 0, 0, 0);
        #1;
        check("sw_mis_ram_req", bus.ram_req, 0);
        cyc();
        set_idle();
        #1;
        check("sw_ades", ades, 1);
        check("sw_adel", adel, 0);
        cyc();
        check("sw_ades_pulse", ades, 0);

        // lw 0x200 with no ack: timeout
        set_instr(1, 0, 0, MEM_SEL_WORD, 0, 32'h200, 1, 5'd9, 32'h418, 0, 0, 0);
        #1;
        n = 0;
        while (stall_req === 1'b1 && n < 40) begin
            n++;
            cyc();
            if (n == 1) set_idle();
            #1;
        end
        check("to_stall_cycles", n, 17);
        check("to_bus_err", bus_err, 1);
        check("to_wb_bubble", reg_write_en_out, 0);
        check("to_ram_req", bus.ram_req, 0);
        // next instruction proceeds; a late ack is ignored
        @(negedge clk);
        set_instr(0, 0, 0, 4'b0000, 0, 32'h0, 0, 5'd0, 32'h41C, 32'hAAAA0000, 32'h0000BBBB, 1);
        exp_q.push_back(exp_now(32'h0));
        bus.ram_ack = 1;
        bus.ram_read_data = 32'h99;
        #1;
        check("to_next_stall", stall_req, 0);
        cyc();
        bus.ram_ack = 0;
        bus.ram_read_data = 0;
        set_idle();
        check("to_bus_err_pulse", bus_err, 0);
        check("to_next_hilo", hilo_write_en_out, 1);
        check("to_q_empty", exp_q.size(), 0);

        // lw 0x300 flushed in the 2nd WAIT cycle together with an ack
        set_instr(1, 0, 0, MEM_SEL_WORD, 0, 32'h300, 1, 5'd10, 32'h420, 0, 0, 0);
        #1;
        cyc();
        set_idle();
        #1;
        cyc();
        flush = 1;
        bus.ram_ack = 1;
        bus.ram_read_data = 32'h55;
        #1;
        check("fl_ram_req_drop", bus.ram_req, 0);
        cyc();
        flush = 0;
        bus.ram_ack = 0;
        bus.ram_read_data = 0;
        #1;
        check("fl_wb_rwe", reg_write_en_out, 0);
        check("fl_wb_rdata", wb_ram_read_data, 0);
        check("fl_stall", stall_req, 0);
        check("fl_ram_req", bus.ram_req, 0);
        cyc();

        // lw 0x400, reset asserted mid-WAIT
        set_instr(1, 0, 0, MEM_SEL_WORD, 0, 32'h400, 1, 5'd11, 32'h424, 0, 0, 0);
        #1;
        cyc();
        set_idle();
        #1;
        check("rw_req_before", bus.ram_req, 1);
        rst_n = 0;
        #1;
        check("rw_ram_req", bus.ram_req, 0);
        check("rw_ram_addr", bus.ram_addr, 0);
        check("rw_stall", stall_req, 0);
        check("rw_wb_rwe", reg_write_en_out, 0);
        cyc();
        rst_n = 1;
        set_instr(0, 0, 0, 4'b0000, 0, 32'h77, 1, 5'd12, 32'h500, 0, 0, 0);
        exp_q.push_back(exp_now(32'h0));
        #1;
        check("rw_add_stall", stall_req, 0);
        cyc();
        set_idle();
        check("rw_add_wb_rwe", reg_write_en_out, 1);
        check("rw_add_q_empty", exp_q.size(), 0);
        cyc();

        check("final_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
